// File: rtl/mem_port_arbiter_pkg.sv
// rtl/mem_port_arbiter_pkg.sv - hold codes and arbiter state encodings
package mem_port_arbiter_pkg;

  localparam int BUS_HOLD_CODE = 2;

  // A stage stalls while hold_code >= its own code, so EX also stalls fetch.
  localparam logic [BUS_HOLD_CODE-1:0] HOLD_CODE_NONE = 2'd0;
  localparam logic [BUS_HOLD_CODE-1:0] HOLD_CODE_IF   = 2'd1;
  localparam logic [BUS_HOLD_CODE-1:0] HOLD_CODE_EX   = 2'd2;

  typedef enum logic [2:0] {
    ARB_IDLE   = 3'd0,
    ARB_REQ_IF = 3'd1,
    ARB_REQ_LS = 3'd2,
    ARB_RSP_IF = 3'd3,
    ARB_RSP_LS = 3'd4
  } arb_state_e;

endpackage

// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - shares one memory port between fetch and load/store
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int ADDR_W        = 64,
  parameter int DATA_W        = 64,
  parameter int LS_STREAK_MAX = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     if_req,
  input  logic [ADDR_W-1:0]        if_addr,
  input  logic                     if_flush,
  output logic                     if_rvalid,
  output logic [DATA_W-1:0]        if_rdata,
  input  logic                     ls_rd_en,
  input  logic                     ls_wr_en,
  input  logic [ADDR_W-1:0]        ls_addr_rd,
  input  logic [ADDR_W-1:0]        ls_addr_wr,
  input  logic [DATA_W-1:0]        ls_wdata,
  output logic                     ls_rvalid,
  output logic [DATA_W-1:0]        ls_rdata,
  output logic                     mem_req,
  output logic                     mem_we,
  output logic [ADDR_W-1:0]        mem_addr,
  output logic [DATA_W-1:0]        mem_wdata,
  input  logic                     mem_gnt,
  input  logic                     mem_rvalid,
  input  logic [DATA_W-1:0]        mem_rdata,
  output logic [BUS_HOLD_CODE-1:0] hold_code
);

  localparam int STREAK_W = $clog2(LS_STREAK_MAX + 1);
  localparam logic [STREAK_W-1:0] STREAK_MAX = STREAK_W'(LS_STREAK_MAX);

  arb_state_e          r_state;
  arb_state_e          w_next;
  logic [STREAK_W-1:0] r_streak;
  logic                r_drop;
  logic [ADDR_W-1:0]   r_addr;
  logic                r_we;
  logic [DATA_W-1:0]   r_wdata;
  logic                r_if_rvalid;
  logic                r_ls_rvalid;
  logic [DATA_W-1:0]   r_if_rdata;
  logic [DATA_W-1:0]   r_ls_rdata;
  logic                w_ls_any;
  logic                w_pick_ls;

  assign w_ls_any  = ls_rd_en | ls_wr_en;
  // LSU has priority unless it has starved a waiting fetch for LS_STREAK_MAX grants.
  assign w_pick_ls = w_ls_any && !((r_streak == STREAK_MAX) && if_req);

  always_ff @(posedge clk) begin
    if (rst) r_state <= ARB_IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      ARB_IDLE: begin
        if (w_pick_ls)   w_next = ARB_REQ_LS;
        else if (if_req) w_next = ARB_REQ_IF;
      end
      ARB_REQ_IF: begin
        if (mem_gnt)       w_next = ARB_RSP_IF;
        else if (if_flush) w_next = ARB_IDLE;
      end
      ARB_REQ_LS: if (mem_gnt)    w_next = ARB_RSP_LS;
      ARB_RSP_IF: if (mem_rvalid) w_next = ARB_IDLE;
      ARB_RSP_LS: if (mem_rvalid) w_next = ARB_IDLE;
      default:    w_next = ARB_IDLE;
    endcase
  end

  always_comb begin
    mem_req   = (r_state == ARB_REQ_IF) || (r_state == ARB_REQ_LS);
    hold_code = HOLD_CODE_NONE;
    if (w_ls_any || r_state == ARB_REQ_LS || r_state == ARB_RSP_LS || r_ls_rvalid)
      hold_code = HOLD_CODE_EX;
    else if (if_req || r_state == ARB_REQ_IF || r_state == ARB_RSP_IF || r_if_rvalid)
      hold_code = HOLD_CODE_IF;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_streak    <= '0;
      r_drop      <= 1'b0;
      r_addr      <= '0;
      r_we        <= 1'b0;
      r_wdata     <= '0;
      r_if_rvalid <= 1'b0;
      r_ls_rvalid <= 1'b0;
      r_if_rdata  <= '0;
      r_ls_rdata  <= '0;
    end else begin
      r_if_rvalid <= 1'b0;
      r_ls_rvalid <= 1'b0;

      if (r_state == ARB_IDLE) begin
        if (w_pick_ls) begin
          r_addr  <= ls_wr_en ? ls_addr_wr : ls_addr_rd;
          r_we    <= ls_wr_en;
          r_wdata <= ls_wr_en ? ls_wdata : '0;
        end else if (if_req) begin
          r_addr  <= if_addr;
          r_we    <= 1'b0;
          r_wdata <= '0;
        end
      end

      // A flush that coincides with the grant cannot withdraw the request; drop its response.
      if (r_state == ARB_REQ_IF && mem_gnt && if_flush) r_drop <= 1'b1;

      if (r_state == ARB_RSP_IF) begin
        if (mem_rvalid) begin
          r_drop <= 1'b0;
          if (!(r_drop || if_flush)) begin
            r_if_rdata  <= mem_rdata;
            r_if_rvalid <= 1'b1;
          end
        end else if (if_flush) begin
          r_drop <= 1'b1;
        end
      end

      if (r_state == ARB_RSP_LS && mem_rvalid) begin
        r_ls_rdata  <= mem_rdata;
        r_ls_rvalid <= 1'b1;
      end

      if (!if_req || (r_state == ARB_REQ_IF && mem_gnt))
        r_streak <= '0;
      else if (r_state == ARB_REQ_LS && mem_gnt && r_streak != STREAK_MAX)
        r_streak <= r_streak + 1'b1;
    end
  end

  assign mem_we    = r_we;
  assign mem_addr  = r_addr;
  assign mem_wdata = r_wdata;
  assign if_rvalid = r_if_rvalid;
  assign if_rdata  = r_if_rdata;
  assign ls_rvalid = r_ls_rvalid;
  assign ls_rdata  = r_ls_rdata;

  a_ls_rw_excl: assert property (@(posedge clk) disable iff (rst) !(ls_rd_en && ls_wr_en));

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb/tb_mem_port_arbiter.sv - directed vector bench for mem_port_arbiter
module tb_mem_port_arbiter;
  import mem_port_arbiter_pkg::*;

  logic        clk;
  logic        rst;
  logic        if_req;
  logic [63:0] if_addr;
  logic        if_flush;
  logic        if_rvalid;
  logic [63:0] if_rdata;
  logic        ls_rd_en;
  logic        ls_wr_en;
  logic [63:0] ls_addr_rd;
  logic [63:0] ls_addr_wr;
  logic [63:0] ls_wdata;
  logic        ls_rvalid;
  logic [63:0] ls_rdata;
  logic        mem_req;
  logic        mem_we;
  logic [63:0] mem_addr;
  logic [63:0] mem_wdata;
  logic        mem_gnt;
  logic        mem_rvalid;
  logic [63:0] mem_rdata;
  logic [1:0]  hold_code;

  int total = 0;
  int bad   = 0;

  mem_port_arbiter #(.ADDR_W(64), .DATA_W(64), .LS_STREAK_MAX(4)) dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_flush(if_flush),
    .if_rvalid(if_rvalid), .if_rdata(if_rdata),
    .ls_rd_en(ls_rd_en), .ls_wr_en(ls_wr_en),
    .ls_addr_rd(ls_addr_rd), .ls_addr_wr(ls_addr_wr), .ls_wdata(ls_wdata),
    .ls_rvalid(ls_rvalid), .ls_rdata(ls_rdata),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_gnt(mem_gnt), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
    .hold_code(hold_code)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic        if_req;
    logic        ls_rd;
    logic        ls_wr;
    logic [63:0] if_addr;
    logic [63:0] rd_addr;
    logic [63:0] wr_addr;
    logic [63:0] wdata;
    logic [63:0] rsp;
    logic [1:0]  exp_hold;
    logic        exp_we;
    logic [63:0] exp_addr;
    logic [63:0] exp_wdata;
    logic        exp_ls;
  } vec_t;

  vec_t vecs [8];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    if_req = 0; if_addr = 0; if_flush = 0;
    ls_rd_en = 0; ls_wr_en = 0; ls_addr_rd = 0; ls_addr_wr = 0; ls_wdata = 0;
    mem_gnt = 0; mem_rvalid = 0; mem_rdata = 0;
    repeat (2) tick();
    rst = 1'b0;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_mem_req"},   mem_req,   0);
    check({tag, "_mem_we"},    mem_we,    0);
    check({tag, "_mem_addr"},  mem_addr,  0);
    check({tag, "_mem_wdata"}, mem_wdata, 0);
    check({tag, "_if_rvalid"}, if_rvalid, 0);
    check({tag, "_ls_rvalid"}, ls_rvalid, 0);
    check({tag, "_if_rdata"},  if_rdata,  0);
    check({tag, "_ls_rdata"},  ls_rdata,  0);
    check({tag, "_hold"},      hold_code, HOLD_CODE_NONE);
  endtask

  bit          order [7];
  bit          exp_order [7];
  int          ngr;
  int          loads_left;
  logic        granted;

  initial begin
    vecs[0] = '{1, 0, 0, 64'h8000_0000, 0, 0, 0, 64'h13, HOLD_CODE_IF, 0, 64'h8000_0000, 0, 0};
    vecs[1] = '{0, 1, 0, 0, 64'h1000, 0, 0, 64'h1122_3344_5566_7788, HOLD_CODE_EX, 0, 64'h1000, 0, 1};
    vecs[2] = '{0, 0, 1, 0, 0, 64'h2008, 64'hDEAD_BEEF, 0, HOLD_CODE_EX, 1, 64'h2008, 64'hDEAD_BEEF, 1};
    vecs[3] = '{1, 1, 0, 64'h8000_0000, 64'h1000, 0, 0, 64'hCAFE, HOLD_CODE_EX, 0, 64'h1000, 0, 1};
    vecs[4] = '{1, 0, 1, 64'h8000_0000, 0, 64'h2008, 64'hDEAD_BEEF, 0, HOLD_CODE_EX, 1, 64'h2008, 64'hDEAD_BEEF, 1};
    vecs[5] = '{0, 1, 0, 0, 64'h3000, 64'h4000, 64'h5555, 64'h77, HOLD_CODE_EX, 0, 64'h3000, 0, 1};
    vecs[6] = '{0, 0, 1, 0, 64'h3000, 64'h4000, 64'h1234, 0, HOLD_CODE_EX, 1, 64'h4000, 64'h1234, 1};
    vecs[7] = '{1, 0, 0, 64'hFFFF_FFFF_FFFF_FFF8, 0, 0, 0, 64'hFFFF_FFFF_FFFF_FFFF, HOLD_CODE_IF, 0,
                64'hFFFF_FFFF_FFFF_FFF8, 0, 0};

    do_reset();
    @(negedge clk);
    check_reset_outputs("reset");

    // Single transactions, immediate grant, response one cycle later.
    for (int i = 0; i < 8; i++) begin
      do_reset();
      tick();
      if_req = vecs[i].if_req; ls_rd_en = vecs[i].ls_rd; ls_wr_en = vecs[i].ls_wr;
      if_addr = vecs[i].if_addr; ls_addr_rd = vecs[i].rd_addr;
      ls_addr_wr = vecs[i].wr_addr; ls_wdata = vecs[i].wdata;
      @(negedge clk);
      check($sformatf("v%0d_hold_c0", i), hold_code, vecs[i].exp_hold);
      check($sformatf("v%0d_req_c0", i), mem_req, 0);
      tick();
      mem_gnt = 1;
      @(negedge clk);
      check($sformatf("v%0d_req_c1", i), mem_req, 1);
      check($sformatf("v%0d_we", i), mem_we, vecs[i].exp_we);
      check($sformatf("v%0d_addr", i), mem_addr, vecs[i].exp_addr);
      if (vecs[i].exp_we) check($sformatf("v%0d_wdata", i), mem_wdata, vecs[i].exp_wdata);
      check($sformatf("v%0d_hold_c1", i), hold_code, vecs[i].exp_hold);
      tick();
      mem_gnt = 0; mem_rvalid = 1; mem_rdata = vecs[i].rsp;
      @(negedge clk);
      check($sformatf("v%0d_req_c2", i), mem_req, 0);
      check($sformatf("v%0d_hold_c2", i), hold_code, vecs[i].exp_hold);
      tick();
      mem_rvalid = 0; mem_rdata = 0;
      @(negedge clk);
      check($sformatf("v%0d_if_rvalid", i), if_rvalid, !vecs[i].exp_ls);
      check($sformatf("v%0d_ls_rvalid", i), ls_rvalid, vecs[i].exp_ls);
      check($sformatf("v%0d_rdata", i), vecs[i].exp_ls ? ls_rdata : if_rdata, vecs[i].rsp);
      check($sformatf("v%0d_hold_c3", i), hold_code, vecs[i].exp_hold);
    end

    // Fetch and load together: load first, fetch issued right after ls_rvalid.
    do_reset();
    tick();
    if_req = 1; if_addr = 64'h8000_0000; ls_rd_en = 1; ls_addr_rd = 64'h1000;
    tick(); mem_gnt = 1;
    tick(); mem_gnt = 0; mem_rvalid = 1; mem_rdata = 64'hAA;
    tick(); mem_rvalid = 0;
    @(negedge clk);
    check("both_ls_rvalid", ls_rvalid, 1);
    check("both_ls_rdata", ls_rdata, 64'hAA);
    check("both_hold_c3", hold_code, HOLD_CODE_EX);
    ls_rd_en = 0;
    tick(); mem_gnt = 1;
    @(negedge clk);
    check("both_if_req_c4", mem_req, 1);
    check("both_if_addr_c4", mem_addr, 64'h8000_0000);
    check("both_if_we_c4", mem_we, 0);
    check("both_hold_c4", hold_code, HOLD_CODE_IF);
    tick(); mem_gnt = 0; mem_rvalid = 1; mem_rdata = 64'h13;
    tick(); mem_rvalid = 0;
    @(negedge clk);
    check("both_if_rvalid_c6", if_rvalid, 1);
    check("both_if_rdata_c6", if_rdata, 64'h13);
    if_req = 0;
    tick();
    @(negedge clk);
    check("both_hold_c7", hold_code, HOLD_CODE_NONE);
    check("both_req_c7", mem_req, 0);

    // Store with grant delayed three cycles; inputs change underneath the held request.
    do_reset();
    tick();
    ls_wr_en = 1; ls_addr_wr = 64'h2008; ls_wdata = 64'hDEAD_BEEF;
    for (int c = 1; c <= 4; c++) begin
      tick();
      mem_gnt = (c == 4);
      mem_rvalid = (c == 2);
      if (c == 2) begin ls_addr_wr = 64'h9999; ls_wdata = 64'h0BAD_F00D; end
      @(negedge clk);
      check($sformatf("st_req_c%0d", c), mem_req, 1);
      check($sformatf("st_we_c%0d", c), mem_we, 1);
      check($sformatf("st_addr_c%0d", c), mem_addr, 64'h2008);
      check($sformatf("st_wdata_c%0d", c), mem_wdata, 64'hDEAD_BEEF);
      if (c == 3) check("st_stray_rvalid", ls_rvalid, 0);
    end
    tick(); mem_gnt = 0; mem_rvalid = 1;
    @(negedge clk);
    check("st_req_c5", mem_req, 0);
    check("st_ls_rvalid_c5", ls_rvalid, 0);
    tick(); mem_rvalid = 0;
    @(negedge clk);
    check("st_ls_rvalid_c6", ls_rvalid, 1);
    check("st_hold_c6", hold_code, HOLD_CODE_EX);

    // Six back-to-back loads with a fetch waiting the whole time.
    do_reset();
    tick();
    if_req = 1; if_addr = 64'h8000_0000; ls_rd_en = 1; ls_addr_rd = 64'h100;
    loads_left = 6; ngr = 0; granted = 0;
    for (int c = 0; c < 300 && ngr < 7; c++) begin
      tick();
      mem_rvalid = granted;
      mem_rdata  = 64'h0;
      granted    = mem_req;
      mem_gnt    = mem_req;
      if (mem_req) begin
        order[ngr] = (mem_addr == 64'h8000_0000);
        ngr++;
      end
      if (ls_rvalid) begin
        loads_left--;
        if (loads_left == 0) ls_rd_en = 0;
        else ls_addr_rd = ls_addr_rd + 64'h8;
      end
    end
    check("starve_grant_count", ngr, 7);
    exp_order = '{0, 0, 0, 0, 1, 0, 0};
    for (int k = 0; k < 7; k++) check($sformatf("starve_grant%0d_is_if", k), order[k], exp_order[k]);

    // Flush while the fetch response is outstanding.
    do_reset();
    mem_gnt = 0; mem_rvalid = 0;
    tick(); if_req = 1; if_addr = 64'h8000_0040;
    tick(); mem_gnt = 1;
    tick(); mem_gnt = 0; if_flush = 1; if_req = 0;
    @(negedge clk);
    check("flrsp_hold_c2", hold_code, HOLD_CODE_IF);
    tick(); if_flush = 0; mem_rvalid = 1; mem_rdata = 64'h77;
    @(negedge clk);
    check("flrsp_if_rvalid_c3", if_rvalid, 0);
    tick(); mem_rvalid = 0;
    @(negedge clk);
    check("flrsp_if_rvalid_c4", if_rvalid, 0);
    check("flrsp_hold_c4", hold_code, HOLD_CODE_NONE);
    check("flrsp_req_c4", mem_req, 0);

    // Flush before grant withdraws the request; redirected fetch follows.
    do_reset();
    tick(); if_req = 1; if_addr = 64'h8000_0080;
    tick(); if_flush = 1;
    @(negedge clk);
    check("flreq_req_c1", mem_req, 1);
    tick(); if_flush = 0; if_addr = 64'h8000_0100; mem_gnt = 1;
    @(negedge clk);
    check("flreq_req_c2", mem_req, 0);
    tick(); mem_gnt = 0;
    @(negedge clk);
    check("flreq_req_c3", mem_req, 1);
    check("flreq_addr_c3", mem_addr, 64'h8000_0100);
    tick(); mem_gnt = 1;
    @(negedge clk);
    check("flreq_req_c4", mem_req, 1);
    tick(); mem_gnt = 0; mem_rvalid = 1; mem_rdata = 64'h55;
    tick(); mem_rvalid = 0; if_req = 0;
    @(negedge clk);
    check("flreq_if_rvalid", if_rvalid, 1);
    check("flreq_if_rdata", if_rdata, 64'h55);

    // Reset while a load response is outstanding.
    do_reset();
    tick(); ls_rd_en = 1; ls_addr_rd = 64'h1000;
    tick(); mem_gnt = 1;
    tick(); mem_gnt = 0;
    @(negedge clk);
    check("rstls_req_c2", mem_req, 0);
    rst = 1; ls_rd_en = 0;
    tick(); rst = 0; mem_rvalid = 1; mem_rdata = 64'h99;
    @(negedge clk);
    check_reset_outputs("rstls_c3");
    tick(); mem_rvalid = 0;
    @(negedge clk);
    check("rstls_ls_rvalid_c4", ls_rvalid, 0);
    check("rstls_ls_rdata_c4", ls_rdata, 0);
    check("rstls_req_c4", mem_req, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
